fsm_bcd_updown_cnt: RTL and testbench
=====================================

Name: fsm_bcd_updown_cnt

Overview:
Parametrised multi-digit BCD up/down counter with a small control FSM, synchronous load/clear, terminal-count output for cascading, and per-digit 7-segment decode. It succeeds the single-digit fixed 0–9 up counter and drives board 7-seg displays for timers and clocks, e.g. a 00–59 seconds field. The count is held in BCD internally; there is no binary-to-BCD conversion.

Parameters:
DIGITS, 2, number of BCD digits (1..4)
MOD, 60, count range 0..MOD-1 (2..10**DIGITS)
SEG_ACTIVE_LOW, 1, 1 = segment lit by 0 (common anode), 0 = segments inverted

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
en  in  1  count enable (level)
up_dn  in  1  1 = count up, 0 = count down
clr  in  1  synchronous clear to 0
load  in  1  synchronous load of load_val
load_val  in  4*DIGITS  BCD value to load; digit 0 = bits [3:0]
bcd  out  4*DIGITS  current count in BCD; digit 0 = LSD
seg  out  7*DIGITS  7-seg per digit, {g,f,e,d,c,b,a}; digit 0 = bits [6:0]
tc  out  1  terminal count, combinational
load_err  out  1  registered 1-cycle pulse: load was rejected
state  out  2  FSM state (debug)

Behaviour:
- Reset (rst=1, async): state=S_RST(00), bcd=0, load_err=0. seg shows "0" on every digit. tc=0.
- FSM states: S_RST=00, S_RUN=01, S_HOLD=10. Code 11 is illegal and goes to S_RST on the next edge.
- S_RST -> S_RUN if en=1, else S_HOLD. The count does not change on the edge that leaves S_RST.
- S_RUN -> S_HOLD when en=0.
- S_HOLD -> S_RUN when en=1.
- clr=1 forces S_RST on the next edge, from any state.
- Count advance: on a rising edge with state==S_RUN and en=1, the count moves ±1 with BCD ripple. Digit carry is 9->0 going up; digit borrow is 0->9 going down.
- Wrap going up: count MOD-1 -> 0. Wrap going down: count 0 -> MOD-1. Both wraps happen in a single edge.
- Edge priority, highest first: clr, then load, then count advance.
  - clr: bcd <= 0; any load or count on that edge is ignored.
  - load: bcd <= load_val; the state is unchanged and no count occurs on that edge.
- Load validation: a load is rejected if any digit is >9 or the value is >=MOD. On rejection, bcd and state are unchanged and load_err=1 for exactly the next cycle.
- Load in S_RST or S_HOLD is accepted and applies normally.
- tc = (state==S_RUN) & en & ((up_dn & bcd==MOD-1) | (~up_dn & bcd==0)). tc is high during the cycle before the wrapping edge, so a cascaded stage uses it as its en.
- up_dn may change on any cycle. It takes effect on the next advancing edge; no extra latency.
- seg is a combinational decode of bcd. Active-low codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - any other value = 1111111 (blank)
  - With SEG_ACTIVE_LOW=0, every code is bitwise inverted.
- Reset mid-count: asynchronous return to reset values; counting resumes only via S_RST -> S_RUN/S_HOLD.
- Arithmetic stays in BCD. No digit register may ever hold a value >9.

Test Plan:
1. Reset, then en=1, up_dn=1, 62 edges -> first edge bcd=00 (S_RST->S_RUN); then 01..59, 00, 01. tc=1 only while bcd=59; seg digit0 for "9"=0010000.
2. en=1, up_dn=0 from 00 -> next advance gives 59 with tc=1 in the cycle before; further edges give 58, 57. Digit borrow 50->49 is correct.
3. Toggle en=0 for 3 cycles at bcd=23 -> state=S_HOLD, bcd stays 23, tc=0. Set en=1 -> S_RUN on the next edge (no advance), then 24.
4. Load 0x45 -> bcd=45 next edge. Load 0x72 (>=MOD) and 0x1A (bad digit) -> bcd unchanged, load_err one-cycle pulse each.
5. Same edge with clr=1, load=1 (0x30), en=1 -> bcd=00, state=S_RST. Same edge with load=1, en=1 -> bcd=load_val, no increment.
6. Assert rst asynchronously mid-cycle at bcd=37 -> bcd=00, state=00 immediately, without waiting for a clock edge. Repeat the check with DIGITS=1, MOD=10, SEG_ACTIVE_LOW=0: seg for "0"=0111111, and the count wraps 9->0.

Source files
------------

// File: rtl/fsm_bcd_updown_cnt.sv
// Multi-digit BCD up/down counter with a run/hold control FSM.
// The count is kept in BCD throughout: increment and decrement ripple digit by digit,
// and the count wraps at MOD-1 going up and at 0 going down.
// Each digit also gets a 7-segment decode, and a terminal-count output lets stages cascade.
//
// Ports
//   clk       : clock, rising edge
//   rst       : asynchronous reset, active-high
//   en        : count enable (level)
//   up_dn     : 1 = count up, 0 = count down
//   clr       : synchronous clear to 0; forces S_RST
//   load      : synchronous load of load_val, after validation
//   load_val  : BCD load value; digit 0 is bits [3:0]
//   bcd       : current count in BCD; digit 0 is the LSD
//   seg       : 7-segment code per digit {g,f,e,d,c,b,a}; digit 0 is bits [6:0]
//   tc        : terminal count (combinational); high in the cycle before a wrap
//   load_err  : registered one-cycle pulse when a load is rejected
//   state     : FSM state, for debug
module fsm_bcd_updown_cnt #(
    parameter int unsigned DIGITS         = 2,
    parameter int unsigned MOD            = 60,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  tc,
    output logic                  load_err,
    output logic [1:0]            state
);

    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned SW = 7 * DIGITS;

    typedef enum logic [1:0] {
        S_RST  = 2'b00,
        S_RUN  = 2'b01,
        S_HOLD = 2'b10,
        S_ILL  = 2'b11
    } state_t;

    // Convert a binary constant to packed BCD (used for the MOD-1 wrap value).
    function automatic logic [BW-1:0] to_bcd(input int unsigned v);
        logic [BW-1:0] res;
        int unsigned   t;
        res = '0;
        t   = v;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            res[4*i +: 4] = 4'(t % 10);
            t             = t / 10;
        end
        return res;
    endfunction

    localparam logic [BW-1:0] MAX_BCD = to_bcd(MOD - 1);

    // A load is valid only if every digit is 0..9 and the value is below MOD.
    function automatic logic load_ok(input logic [BW-1:0] v);
        int unsigned acc;
        int unsigned w;
        logic        ok;
        acc = 0;
        w   = 1;
        ok  = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
            acc = acc + 32'(v[4*i +: 4]) * w;
            w   = w * 10;
        end
        return ok && (acc < MOD);
    endfunction

    // BCD +1 with a digit carry from 9 to 0.
    function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
        logic [BW-1:0] res;
        logic          carry;
        res   = v;
        carry = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (res[4*i +: 4] == 4'd9) begin
                    res[4*i +: 4] = 4'd0;
                end else begin
                    res[4*i +: 4] = res[4*i +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
        return res;
    endfunction

    // BCD -1 with a digit borrow from 0 to 9.
    function automatic logic [BW-1:0] bcd_dec(input logic [BW-1:0] v);
        logic [BW-1:0] res;
        logic          borrow;
        res    = v;
        borrow = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (res[4*i +: 4] == 4'd0) begin
                    res[4*i +: 4] = 4'd9;
                end else begin
                    res[4*i +: 4] = res[4*i +: 4] - 4'd1;
                    borrow        = 1'b0;
                end
            end
        end
        return res;
    endfunction

    // Active-low 7-segment code {g,f,e,d,c,b,a}; non-BCD values are blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    state_t          r_state;
    state_t          w_state_nxt;
    logic [BW-1:0]   r_bcd;
    logic [BW-1:0]   w_bcd_nxt;
    logic            r_load_err;
    logic            w_load_err_nxt;
    logic            w_load_ok;
    logic            w_at_max;
    logic            w_at_zero;
    logic [SW-1:0]   w_seg;

    assign w_at_max  = (r_bcd == MAX_BCD);
    assign w_at_zero = (r_bcd == BW'(0));

    // State, count and load-error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_RST;
            r_bcd      <= '0;
            r_load_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bcd      <= w_bcd_nxt;
            r_load_err <= w_load_err_nxt;
        end
    end

    // Next state and next count. Priority is clr, then load, then count advance.
    always_comb begin
        w_state_nxt    = r_state;
        w_bcd_nxt      = r_bcd;
        w_load_err_nxt = 1'b0;
        w_load_ok      = load_ok(load_val);

        case (r_state)
            S_RST:   w_state_nxt = en ? S_RUN : S_HOLD;
            S_RUN:   w_state_nxt = en ? S_RUN : S_HOLD;
            S_HOLD:  w_state_nxt = en ? S_RUN : S_HOLD;
            default: w_state_nxt = S_RST;
        endcase

        if (clr) begin
            w_state_nxt = S_RST;
            w_bcd_nxt   = '0;
        end else if (load) begin
            // A load freezes the state for that edge; only an illegal code still recovers.
            w_state_nxt = (r_state == S_ILL) ? S_RST : r_state;
            if (w_load_ok) begin
                w_bcd_nxt = load_val;
            end else begin
                w_load_err_nxt = 1'b1;
            end
        end else if ((r_state == S_RUN) && en) begin
            if (up_dn) begin
                w_bcd_nxt = w_at_max ? '0 : bcd_inc(r_bcd);
            end else begin
                w_bcd_nxt = w_at_zero ? MAX_BCD : bcd_dec(r_bcd);
            end
        end
    end

    // Per-digit segment decode, with optional polarity inversion.
    always_comb begin
        w_seg = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            w_seg[7*i +: 7] = SEG_ACTIVE_LOW ? seg_decode(r_bcd[4*i +: 4])
                                             : ~seg_decode(r_bcd[4*i +: 4]);
        end
    end

    assign tc       = (r_state == S_RUN) & en & ((up_dn & w_at_max) | (~up_dn & w_at_zero));
    assign bcd      = r_bcd;
    assign seg      = w_seg;
    assign load_err = r_load_err;
    assign state    = r_state;

endmodule

// File: tb/tb_fsm_bcd_updown_cnt.sv
// Scoreboard bench for fsm_bcd_updown_cnt.
// Two instances are used: the default 2-digit mod-60 counter, and a 1-digit mod-10
// counter with inverted segment polarity.
module tb_fsm_bcd_updown_cnt;

    typedef struct {
        int          sel;
        logic [7:0]  bcd;
        logic [1:0]  st;
        logic        tc;
        logic        le;
        logic [13:0] seg;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic clk = 1'b0;
    logic chk = 1'b0;

    // instance 0: DIGITS=2, MOD=60, active-low segments
    logic        rst, en, up_dn, clr, load;
    logic [7:0]  load_val;
    logic [7:0]  bcd;
    logic [13:0] seg;
    logic        tc, load_err;
    logic [1:0]  state;

    // instance 1: DIGITS=1, MOD=10, active-high segments
    logic        rst2, en2, up2, clr2, ld2;
    logic [3:0]  lv2;
    logic [3:0]  bcd2;
    logic [6:0]  seg2;
    logic        tc2, lerr2;
    logic [1:0]  st2;

    fsm_bcd_updown_cnt #(.DIGITS(2), .MOD(60), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .bcd(bcd), .seg(seg), .tc(tc), .load_err(load_err),
        .state(state)
    );

    fsm_bcd_updown_cnt #(.DIGITS(1), .MOD(10), .SEG_ACTIVE_LOW(1'b0)) dut2 (
        .clk(clk), .rst(rst2), .en(en2), .up_dn(up2), .clr(clr2), .load(ld2),
        .load_val(lv2), .bcd(bcd2), .seg(seg2), .tc(tc2), .load_err(lerr2),
        .state(st2)
    );

    always #5 clk = ~clk;

    // Segment codes written out from the display table.
    function automatic logic [6:0] seg_lo(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [13:0] exp_seg(input int sel, input logic [7:0] b);
        if (sel == 0) return {seg_lo(b[7:4]), seg_lo(b[3:0])};
        return {7'b0, ~seg_lo(b[3:0])};
    endfunction

    function automatic logic [7:0] d2b(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    task automatic push(input int sel, input logic [7:0] eb, input logic [1:0] es,
                        input logic etc, input logic ele, input string nm);
        exp_t e;
        e.sel = sel;
        e.bcd = eb;
        e.st  = es;
        e.tc  = etc;
        e.le  = ele;
        e.seg = exp_seg(sel, eb);
        e.nm  = nm;
        sb.push_back(e);
    endtask

    // Entered at a falling edge: drive inputs, queue the state expected after the next
    // rising edge, and return at the following falling edge.
    task automatic step(input int sel, input logic e, input logic u, input logic c,
                        input logic l, input logic [7:0] lv, input logic [7:0] eb,
                        input logic [1:0] es, input logic etc, input logic ele,
                        input string nm);
        if (sel == 0) begin
            en = e; up_dn = u; clr = c; load = l; load_val = lv;
        end else begin
            en2 = e; up2 = u; clr2 = c; ld2 = l; lv2 = lv[3:0];
        end
        push(sel, eb, es, etc, ele, nm);
        @(negedge clk);
    endtask

    // Assert reset mid-cycle, check it took effect before any clock edge, then release it.
    task automatic async_rst(input int sel, input string nm);
        #2;
        if (sel == 0) rst = 1'b1; else rst2 = 1'b1;
        #1;
        push(sel, 8'h00, 2'b00, 1'b0, 1'b0, nm);
        chk = 1'b1;
        #1;
        chk = 1'b0;
        @(negedge clk);
        if (sel == 0) begin
            rst = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0;
        end else begin
            rst2 = 1'b0; en2 = 1'b0; clr2 = 1'b0; ld2 = 1'b0;
        end
    endtask

    task automatic cmp(input string nm, input string f, input logic [13:0] a,
                       input logic [13:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s.%s got %h expected %h", nm, f, a, x);
        end
    endtask

    // Monitor: compares queued expectations after each rising edge or explicit strobe.
    initial begin
        exp_t        e;
        logic [13:0] a_bcd, a_seg;
        logic [1:0]  a_st;
        logic        a_tc, a_le;
        forever begin
            @(posedge clk or posedge chk);
            #1;
            while (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.sel == 0) begin
                    a_bcd = {6'b0, bcd}; a_st = state; a_tc = tc; a_le = load_err; a_seg = seg;
                end else begin
                    a_bcd = {10'b0, bcd2}; a_st = st2; a_tc = tc2; a_le = lerr2;
                    a_seg = {7'b0, seg2};
                end
                cmp(e.nm, "bcd",   a_bcd, {6'b0, e.bcd});
                cmp(e.nm, "state", {12'b0, a_st}, {12'b0, e.st});
                cmp(e.nm, "tc",    {13'b0, a_tc}, {13'b0, e.tc});
                cmp(e.nm, "lerr",  {13'b0, a_le}, {13'b0, e.le});
                cmp(e.nm, "seg",   a_seg, e.seg);
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1; en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0; load_val = 8'h00;
        rst2 = 1'b1; en2 = 1'b0; up2 = 1'b1; clr2 = 1'b0; ld2 = 1'b0; lv2 = 4'h0;

        // reset values on both instances
        #2;
        push(0, 8'h00, 2'b00, 1'b0, 1'b0, "reset");
        push(1, 8'h00, 2'b00, 1'b0, 1'b0, "reset2");
        chk = 1'b1;
        #1;
        chk = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // up count through the wrap: 00 (leave S_RST), 01..59, 00, 01
        for (int k = 1; k <= 62; k++) begin
            n = (k - 1) % 60;
            step(0, 1, 1, 0, 0, 8'h00, d2b(n), 2'b01, (n == 59), 0, "t1_up");
        end

        // down count: 00, wrap to 59, then down to 49 across the 50->49 borrow
        n = 1;
        for (int k = 1; k <= 12; k++) begin
            n = (n == 0) ? 59 : n - 1;
            step(0, 1, 0, 0, 0, 8'h00, d2b(n), 2'b01, (n == 0), 0, "t2_down");
        end

        // hold at 23, resume without advancing, then advance
        step(0, 1, 1, 0, 1, 8'h23, 8'h23, 2'b01, 0, 0, "t3_load23");
        for (int k = 0; k < 3; k++)
            step(0, 0, 1, 0, 0, 8'h00, 8'h23, 2'b10, 0, 0, "t3_hold");
        step(0, 1, 1, 0, 0, 8'h00, 8'h23, 2'b01, 0, 0, "t3_resume");
        step(0, 1, 1, 0, 0, 8'h00, 8'h24, 2'b01, 0, 0, "t3_adv");

        // load validation
        step(0, 1, 1, 0, 1, 8'h45, 8'h45, 2'b01, 0, 0, "t4_load45");
        step(0, 1, 1, 0, 1, 8'h72, 8'h45, 2'b01, 0, 1, "t4_rej72");
        step(0, 0, 1, 0, 0, 8'h00, 8'h45, 2'b10, 0, 0, "t4_pulse_end");
        step(0, 0, 1, 0, 1, 8'h1A, 8'h45, 2'b10, 0, 1, "t4_rej1A");
        step(0, 0, 1, 0, 0, 8'h00, 8'h45, 2'b10, 0, 0, "t4_pulse_end2");

        // priority: clr over load over count
        step(0, 1, 1, 1, 1, 8'h30, 8'h00, 2'b00, 0, 0, "t5_clr_load");
        step(0, 1, 1, 1, 1, 8'h72, 8'h00, 2'b00, 0, 0, "t5_clr_badload");
        step(0, 1, 1, 0, 1, 8'h30, 8'h30, 2'b00, 0, 0, "t5_load_no_inc");
        step(0, 1, 1, 0, 0, 8'h00, 8'h30, 2'b01, 0, 0, "t5_leave_rst");
        for (int k = 31; k <= 37; k++)
            step(0, 1, 1, 0, 0, 8'h00, d2b(k), 2'b01, 0, 0, "t5_count");

        // asynchronous reset at 37
        async_rst(0, "t6_async");

        // boundary loads: MOD-1 accepted, MOD rejected
        step(0, 1, 1, 0, 1, 8'h59, 8'h59, 2'b00, 0, 0, "b_load59");
        step(0, 1, 1, 0, 0, 8'h00, 8'h59, 2'b01, 1, 0, "b_tc59");
        step(0, 1, 1, 0, 0, 8'h00, 8'h00, 2'b01, 0, 0, "b_wrap");
        step(0, 0, 1, 0, 1, 8'h60, 8'h00, 2'b01, 0, 1, "b_rej60");
        step(0, 0, 1, 0, 0, 8'h00, 8'h00, 2'b10, 0, 0, "b_hold");

        // single-digit instance: wrap 9->0, async reset, down wrap 0->9
        rst2 = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            n = (k - 1) % 10;
            step(1, 1, 1, 0, 0, 8'h00, d2b(n), 2'b01, (n == 9), 0, "d1_up");
        end
        async_rst(1, "d1_async");
        step(1, 1, 0, 0, 0, 8'h00, 8'h00, 2'b01, 1, 0, "d1_tc0");
        step(1, 1, 0, 0, 0, 8'h00, 8'h09, 2'b01, 0, 0, "d1_wrap_dn");
        step(1, 0, 0, 0, 1, 8'h0A, 8'h09, 2'b01, 0, 1, "d1_rejA");
        step(1, 0, 0, 0, 0, 8'h00, 8'h09, 2'b10, 0, 0, "d1_hold");

        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
